sprite_palette_lut: RTL and testbench

Runtime-writable, multi-bank sprite palette for the VGA pixel path. Maps a per-pixel colour index plus bank select to 12-bit RGB through a two-stage registered pipeline, flags the transparent index, and applies frame-synchronous colour cycling over a programmable index range. Sits between the sprite ROM readout and the pixel mux. It replaces the fixed per-sprite combinational palettes, so team or state recolouring becomes a bank switch.

---
 rtl/sprite_palette_lut.sv | 135 +++++++++++++
 tb/tb_sprite_palette_lut.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_palette_lut.sv
// Multi-bank runtime-writable sprite palette with transparency flag
// and frame-synchronous colour cycling over a programmable index range.
module sprite_palette_lut #(
    parameter int INDEX_W      = 4,
    parameter int COLOR_W      = 4,
    parameter int BANKS        = 4,
    parameter int BANK_W       = $clog2(BANKS),
    parameter int TRANSP_INDEX = 0,
    parameter int PERIOD_W     = 6
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 we,
    input  logic [BANK_W-1:0]    wr_bank,
    input  logic [INDEX_W-1:0]   wr_index,
    input  logic [3*COLOR_W-1:0] wr_rgb,
    input  logic                 pix_valid_in,
    input  logic [BANK_W-1:0]    pix_bank,
    input  logic [INDEX_W-1:0]   pix_index,
    input  logic                 frame_start,
    input  logic                 cyc_en,
    input  logic [INDEX_W-1:0]   cyc_lo,
    input  logic [INDEX_W-1:0]   cyc_hi,
    input  logic [PERIOD_W-1:0]  cyc_period,
    output logic                 pix_valid_out,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 transparent
);

    localparam int DEPTH = 2 ** INDEX_W;
    localparam int RGB_W = 3 * COLOR_W;
    localparam logic [INDEX_W:0] ONE_X = 1;
    localparam logic [INDEX_W-1:0] TRANSP_I = INDEX_W'(TRANSP_INDEX);

    logic [RGB_W-1:0] mem [BANKS][DEPTH];

    logic                rng_ok;
    logic                in_rng;
    logic [INDEX_W:0]    len;
    logic [INDEX_W:0]    phase_x;
    logic [INDEX_W:0]    phase_inc;
    logic [INDEX_W:0]    phase_nxt;
    logic [INDEX_W:0]    p;
    logic [INDEX_W:0]    s;
    logic [INDEX_W:0]    s_wrap;
    logic [INDEX_W-1:0]  eidx;
    logic [PERIOD_W-1:0] period_m1;
    logic [PERIOD_W-1:0] fcnt;
    logic [INDEX_W-1:0]  phase;

    logic                s1_valid;
    logic [BANK_W-1:0]   s1_bank;
    logic [INDEX_W-1:0]  s1_eidx;
    logic                s1_transp;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int b = 0; b < BANKS; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[b][i] <= '0;
                end
            end
        end else if (we) begin
            mem[wr_bank][wr_index] <= wr_wrap(wr_rgb);
        end
    end

    function automatic logic [RGB_W-1:0] wr_wrap(input logic [RGB_W-1:0] v);
        return v;
    endfunction

    // len is one bit wider so a full 2^INDEX_W range is representable
    assign rng_ok    = cyc_en && (cyc_lo <= cyc_hi);
    assign len       = {1'b0, cyc_hi} - {1'b0, cyc_lo} + ONE_X;
    assign period_m1 = (cyc_period == '0) ? '0
                                          : cyc_period - PERIOD_W'(1);
    assign phase_x   = {1'b0, phase};
    assign phase_inc = phase_x + ONE_X;
    assign phase_nxt = (phase_inc >= len) ? '0 : phase_inc;

    always_ff @(posedge Clk) begin
        if (Reset || !rng_ok) begin
            fcnt  <= '0;
            phase <= '0;
        end else if (frame_start) begin
            if (fcnt == period_m1) begin
                fcnt  <= '0;
                phase <= INDEX_W'(phase_nxt);
            end else begin
                fcnt <= fcnt + PERIOD_W'(1);
            end
        end
    end

    // a range that shrank below the current phase is treated as phase 0
    assign in_rng = rng_ok && (pix_index >= cyc_lo) && (pix_index <= cyc_hi);
    assign p      = (phase_x >= len) ? '0 : phase_x;
    assign s      = {1'b0, pix_index} - {1'b0, cyc_lo} + p;
    assign s_wrap = (s >= len) ? s - len : s;
    assign eidx   = in_rng ? INDEX_W'({1'b0, cyc_lo} + s_wrap) : pix_index;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid  <= 1'b0;
            s1_bank   <= '0;
            s1_eidx   <= '0;
            s1_transp <= 1'b0;
        end else begin
            s1_valid  <= pix_valid_in;
            s1_bank   <= pix_bank;
            s1_eidx   <= eidx;
            s1_transp <= (pix_index == TRANSP_I);
        end
    end

    // read sees pre-write contents on a same-edge collision
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix_valid_out <= 1'b0;
            red           <= '0;
            green         <= '0;
            blue          <= '0;
            transparent   <= 1'b0;
        end else begin
            pix_valid_out <= s1_valid;
            if (s1_valid) begin
                {red, green, blue} <= mem[s1_bank][s1_eidx];
                transparent        <= s1_transp;
            end
        end
    end

endmodule

// File: tb/tb_sprite_palette_lut.sv
// Directed bench for sprite_palette_lut: lookup, banks, collision,
// colour cycling, degenerate range and mid-stream reset.
module tb_sprite_palette_lut;

    logic        Clk;
    logic        Reset;
    logic        we;
    logic [1:0]  wr_bank;
    logic [3:0]  wr_index;
    logic [11:0] wr_rgb;
    logic        pix_valid_in;
    logic [1:0]  pix_bank;
    logic [3:0]  pix_index;
    logic        frame_start;
    logic        cyc_en;
    logic [3:0]  cyc_lo;
    logic [3:0]  cyc_hi;
    logic [5:0]  cyc_period;
    logic        pix_valid_out;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        transparent;
    logic [11:0] rgb;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] exp4 [7] = '{12'h100, 12'h100, 12'h200, 12'h200,
                              12'h300, 12'h300, 12'h100};

    assign rgb = {red, green, blue};

    sprite_palette_lut dut (
        .Clk(Clk),
        .Reset(Reset),
        .we(we),
        .wr_bank(wr_bank),
        .wr_index(wr_index),
        .wr_rgb(wr_rgb),
        .pix_valid_in(pix_valid_in),
        .pix_bank(pix_bank),
        .pix_index(pix_index),
        .frame_start(frame_start),
        .cyc_en(cyc_en),
        .cyc_lo(cyc_lo),
        .cyc_hi(cyc_hi),
        .cyc_period(cyc_period),
        .pix_valid_out(pix_valid_out),
        .red(red),
        .green(green),
        .blue(blue),
        .transparent(transparent)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] b, input logic [3:0] i,
                      input logic [11:0] v);
        we       = 1'b1;
        wr_bank  = b;
        wr_index = i;
        wr_rgb   = v;
        step();
        we = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [1:0] b,
                          input logic [3:0] i, input logic [11:0] e,
                          input logic et);
        pix_valid_in = 1'b1;
        pix_bank     = b;
        pix_index    = i;
        step();
        pix_valid_in = 1'b0;
        step();
        check({tag, "_vld"}, 32'(pix_valid_out), 32'd1);
        check({tag, "_rgb"}, 32'(rgb), 32'(e));
        check({tag, "_tr"}, 32'(transparent), 32'(et));
    endtask

    initial begin
        Reset        = 1'b1;
        we           = 1'b0;
        wr_bank      = '0;
        wr_index     = '0;
        wr_rgb       = '0;
        pix_valid_in = 1'b0;
        pix_bank     = '0;
        pix_index    = '0;
        frame_start  = 1'b0;
        cyc_en       = 1'b0;
        cyc_lo       = '0;
        cyc_hi       = '0;
        cyc_period   = '0;
        step();
        step();
        check("rst_vld", 32'(pix_valid_out), 32'd0);
        check("rst_rgb", 32'(rgb), 32'd0);
        check("rst_tr", 32'(transparent), 32'd0);
        Reset = 1'b0;

        lookup("b2i5", 2'd2, 4'd5, 12'h000, 1'b0);
        lookup("b2i0", 2'd2, 4'd0, 12'h000, 1'b1);

        wr(2'd1, 4'd3, 12'hC25);
        wr(2'd0, 4'd3, 12'h982);
        pix_valid_in = 1'b1;
        pix_bank     = 2'd1;
        pix_index    = 4'd3;
        step();
        pix_bank = 2'd0;
        step();
        pix_valid_in = 1'b0;
        check("strm0_vld", 32'(pix_valid_out), 32'd1);
        check("strm0_rgb", 32'(rgb), 32'hC25);
        step();
        check("strm1_vld", 32'(pix_valid_out), 32'd1);
        check("strm1_rgb", 32'(rgb), 32'h982);
        step();
        check("idle_vld", 32'(pix_valid_out), 32'd0);
        check("idle_hold", 32'(rgb), 32'h982);

        wr(2'd0, 4'd7, 12'h123);
        pix_valid_in = 1'b1;
        pix_bank     = 2'd0;
        pix_index    = 4'd7;
        step();
        pix_valid_in = 1'b0;
        we           = 1'b1;
        wr_bank      = 2'd0;
        wr_index     = 4'd7;
        wr_rgb       = 12'hFE8;
        step();
        we = 1'b0;
        check("coll_vld", 32'(pix_valid_out), 32'd1);
        check("coll_old", 32'(rgb), 32'h123);
        lookup("coll_new", 2'd0, 4'd7, 12'hFE8, 1'b0);

        wr(2'd0, 4'd4, 12'h100);
        wr(2'd0, 4'd5, 12'h200);
        wr(2'd0, 4'd6, 12'h300);
        cyc_lo     = 4'd4;
        cyc_hi     = 4'd6;
        cyc_period = 6'd2;
        cyc_en     = 1'b1;
        step();
        for (int f = 0; f < 7; f++) begin
            lookup($sformatf("cyc4_f%0d", f), 2'd0, 4'd4, exp4[f], 1'b0);
            lookup($sformatf("cyc3_f%0d", f), 2'd0, 4'd3, 12'h982, 1'b0);
            if (f == 2) lookup("cyc6_f2", 2'd0, 4'd6, 12'h100, 1'b0);
            if (f == 4) lookup("cyc5_f4", 2'd0, 4'd5, 12'h100, 1'b0);
            if (f == 3) lookup("cyc0_f3", 2'd0, 4'd0, 12'h000, 1'b1);
            if (f < 6) frame();
        end

        cyc_lo = 4'd9;
        cyc_hi = 4'd2;
        for (int k = 0; k < 10; k++) frame();
        lookup("deg4", 2'd0, 4'd4, 12'h100, 1'b0);
        lookup("deg5", 2'd0, 4'd5, 12'h200, 1'b0);
        cyc_lo     = 4'd4;
        cyc_hi     = 4'd6;
        cyc_period = 6'd0;
        step();
        lookup("p0_ph0", 2'd0, 4'd4, 12'h100, 1'b0);
        frame();
        lookup("p0_ph1", 2'd0, 4'd4, 12'h200, 1'b0);
        frame();
        lookup("p0_ph2", 2'd0, 4'd4, 12'h300, 1'b0);

        pix_valid_in = 1'b1;
        pix_bank     = 2'd0;
        pix_index    = 4'd4;
        step();
        pix_index   = 4'd5;
        Reset       = 1'b1;
        frame_start = 1'b1;
        we          = 1'b1;
        wr_bank     = 2'd1;
        wr_index    = 4'd3;
        wr_rgb      = 12'hABC;
        step();
        Reset        = 1'b0;
        frame_start  = 1'b0;
        we           = 1'b0;
        pix_valid_in = 1'b0;
        check("mrst_vld0", 32'(pix_valid_out), 32'd0);
        check("mrst_rgb0", 32'(rgb), 32'd0);
        step();
        check("mrst_vld1", 32'(pix_valid_out), 32'd0);
        step();
        check("mrst_vld2", 32'(pix_valid_out), 32'd0);
        lookup("mrst_b1i3", 2'd1, 4'd3, 12'h000, 1'b0);
        lookup("mrst_b0i7", 2'd0, 4'd7, 12'h000, 1'b0);
        wr(2'd0, 4'd4, 12'h100);
        wr(2'd0, 4'd5, 12'h200);
        wr(2'd0, 4'd6, 12'h300);
        lookup("mrst_ph0", 2'd0, 4'd4, 12'h100, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
